// File: rtl/stopwatch_counter_if.sv
// ---------------------------------------------------------------------------
// stopwatch_counter_if
// Purpose : Groups the stopwatch control inputs and the time/status outputs
//           exchanged between the stopwatch core and its environment.
// Signals : pause     - single-cycle run/pause toggle pulse (to core)
//           adjust    - level, 1 = adjust mode (to core)
//           selection - level, 1 = adjust seconds, 0 = adjust minutes (to core)
//           min       - minutes 0..59, binary (from core)
//           sec       - seconds 0..59, binary (from core)
//           running   - 1 while counting is live (from core)
//           sec_tick  - one-cycle pulse when min/sec change (from core)
// Modports: master - environment side (drives controls)
//           slave  - stopwatch core side (drives time/status)
// ---------------------------------------------------------------------------
interface stopwatch_counter_if;
   logic       pause;
   logic       adjust;
   logic       selection;
   logic [5:0] min;
   logic [5:0] sec;
   logic       running;
   logic       sec_tick;

   modport master (
      output pause, adjust, selection,
      input  min, sec, running, sec_tick
   );

   modport slave (
      input  pause, adjust, selection,
      output min, sec, running, sec_tick
   );
endinterface

// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
// Purpose : Stopwatch timekeeping core. Divides clk into a 1 Hz count enable,
//           keeps mm:ss (00:00..59:59), implements run/pause and adjust mode.
// Params  : TICK_DIV - clk cycles per counted second (>= 2)
//           ADJ_DIV  - clk cycles per adjust-mode step (>= 2)
// Ports   : clk - system clock, rising edge
//           rst - synchronous active-high reset
//           sw  - stopwatch_counter_if.slave (pause/adjust/selection in,
//                 min/sec/running/sec_tick out, all outputs registered)
// Config  : STOPWATCH_SATURATE_EN - when defined, normal counting stops at
//           59:59 and forces PAUSED; otherwise 59:59 wraps to 00:00.
// ---------------------------------------------------------------------------
module stopwatch_counter #(
   parameter int unsigned TICK_DIV = 100_000_000,
   parameter int unsigned ADJ_DIV  = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   stopwatch_counter_if.slave  sw
);

   localparam int unsigned SDIV_W  = $clog2(TICK_DIV);
   localparam int unsigned ADIV_W  = $clog2(ADJ_DIV);
   localparam int unsigned FIELD_W = 6;

   localparam logic [SDIV_W-1:0]  SDIV_LAST = SDIV_W'(TICK_DIV - 1);
   localparam logic [ADIV_W-1:0]  ADIV_LAST = ADIV_W'(ADJ_DIV - 1);
   localparam logic [FIELD_W-1:0] FIELD_MAX = FIELD_W'(59);

   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_PAUSED = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [SDIV_W-1:0]    sdiv_q, sdiv_d;
   logic [ADIV_W-1:0]    adiv_q, adiv_d;
   logic [FIELD_W-1:0]   min_q, min_d;
   logic [FIELD_W-1:0]   sec_q, sec_d;
   logic                 tick_q, tick_d;
   logic                 running_q, running_d;
   logic                 adjust_q;
   logic                 selection_q;

   // Modulo-60 increment used by adjust mode (no carry between fields).
   function automatic logic [FIELD_W-1:0] inc60(input logic [FIELD_W-1:0] v);
      return (v == FIELD_MAX) ? '0 : v + FIELD_W'(1);
   endfunction

   // Next-state: run/pause toggle, second/adjust dividers, time fields.
   always_comb begin
      state_d   = state_q;
      sdiv_d    = sdiv_q;
      adiv_d    = adiv_q;
      min_d     = min_q;
      sec_d     = sec_q;
      tick_d    = 1'b0;

      // Pause pulses toggle the state even in adjust mode.
      if (sw.pause) begin
         state_d = (state_q == ST_RUN) ? ST_PAUSED : ST_RUN;
      end

      if (adjust_q) begin
         sdiv_d = '0;
         if (adiv_q == ADIV_LAST) begin
            adiv_d = '0;
            tick_d = 1'b1;
            if (selection_q) begin
               sec_d = inc60(sec_q);
            end else begin
               min_d = inc60(min_q);
            end
         end else begin
            adiv_d = adiv_q + ADIV_W'(1);
         end
      end else begin
         adiv_d = '0;
         // A pause pulse while running suppresses the advance, so a wrap
         // landing on that edge is held at SDIV_LAST until after resume.
         if ((state_q == ST_RUN) && !sw.pause) begin
            if (sdiv_q == SDIV_LAST) begin
               sdiv_d = '0;
               if ((sec_q == FIELD_MAX) && (min_q == FIELD_MAX)) begin
`ifdef STOPWATCH_SATURATE_EN
                  state_d = ST_PAUSED;
`else
                  min_d  = '0;
                  sec_d  = '0;
                  tick_d = 1'b1;
`endif
               end else if (sec_q == FIELD_MAX) begin
                  sec_d  = '0;
                  min_d  = min_q + FIELD_W'(1);
                  tick_d = 1'b1;
               end else begin
                  sec_d  = sec_q + FIELD_W'(1);
                  tick_d = 1'b1;
               end
            end else begin
               sdiv_d = sdiv_q + SDIV_W'(1);
            end
         end
      end

      // Tracks the registered adjust level that will be in force next cycle.
      running_d = (state_d == ST_RUN) && !sw.adjust;
   end

   // State register; rst wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         sdiv_q      <= '0;
         adiv_q      <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         tick_q      <= 1'b0;
         running_q   <= 1'b1;
         adjust_q    <= 1'b0;
         selection_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sdiv_q      <= sdiv_d;
         adiv_q      <= adiv_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         tick_q      <= tick_d;
         running_q   <= running_d;
         adjust_q    <= sw.adjust;
         selection_q <= sw.selection;
      end
   end

   assign sw.min      = min_q;
   assign sw.sec      = sec_q;
   assign sw.running  = running_q;
   assign sw.sec_tick = tick_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_counter
// Purpose : Self-checking bench for stopwatch_counter with TICK_DIV=4,
//           ADJ_DIV=2. Directed scenarios plus a randomized run compared
//           against a total-seconds reference model.
// ---------------------------------------------------------------------------
module tb_stopwatch_counter;

   localparam int TICK = 4;
   localparam int ADJ  = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   // Reference model state (updated once per rising edge).
   int   m_min, m_sec, m_part, m_acnt;
   bit   m_run, m_adj, m_sel, m_tick;

   stopwatch_counter_if swif ();

   stopwatch_counter #(
      .TICK_DIV (TICK),
      .ADJ_DIV  (ADJ)
   ) dut (
      .clk (clk),
      .rst (rst),
      .sw  (swif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge and update the reference model from the inputs
   // seen on that edge; returns 1 time unit after the edge.
   task automatic tick_edge();
      bit p, r, a, s;
      int total;
      @(posedge clk);
      p = swif.pause; a = swif.adjust; s = swif.selection; r = rst;
      if (r) begin
         m_min = 0; m_sec = 0; m_part = 0; m_acnt = 0;
         m_run = 1; m_adj = 0; m_sel = 0; m_tick = 0;
      end else begin
         m_tick = 0;
         if (m_adj) begin
            m_part = 0;
            m_acnt = m_acnt + 1;
            if (m_acnt == ADJ) begin
               m_acnt = 0;
               m_tick = 1;
               if (m_sel) m_sec = (m_sec + 1) % 60;
               else       m_min = (m_min + 1) % 60;
            end
         end else begin
            m_acnt = 0;
            if (m_run && !p) begin
               m_part = m_part + 1;
               if (m_part == TICK) begin
                  m_part = 0;
                  total  = m_min * 60 + m_sec;
`ifdef STOPWATCH_SATURATE_EN
                  if (total == 3599) begin
                     m_run = 0;
                  end else begin
                     total  = total + 1;
                     m_tick = 1;
                  end
`else
                  total  = (total + 1) % 3600;
                  m_tick = 1;
`endif
                  m_min = total / 60;
                  m_sec = total % 60;
               end
            end
         end
         if (p) m_run = !m_run;
         m_adj = a;
         m_sel = s;
      end
      #1;
   endtask

   task automatic pulse_pause();
      swif.pause = 1'b1;
      tick_edge();
      swif.pause = 1'b0;
   endtask

   // Preload mm:ss through adjust mode, leaving the core in RUN with
   // adjust just sampled low.
   task automatic set_time(input int mm, input int ss);
      int cnt;
      if (!m_run) pulse_pause();
      swif.adjust    = 1'b1;
      swif.selection = 1'b0;
      cnt = 0;
      while ((int'(swif.min) != mm) && (cnt < 400)) begin tick_edge(); cnt++; end
      swif.selection = 1'b1;
      while ((int'(swif.sec) != ss) && (cnt < 800)) begin tick_edge(); cnt++; end
      swif.adjust = 1'b0;
      tick_edge();
      n_checks++;
      if (cnt >= 800) begin
         n_fail++;
         $display("FAIL set_time: reached %0d:%0d, required %0d:%0d", swif.min, swif.sec, mm, ss);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      swif.pause = 1'b0; swif.adjust = 1'b0; swif.selection = 1'b0;
      tick_edge();
      tick_edge();
      n_checks++;
      if ({swif.min, swif.sec} !== 12'd0) begin
         n_fail++; $display("FAIL reset_time: got %0d:%0d, required 0:0", swif.min, swif.sec);
      end
      n_checks++;
      if (swif.running !== 1'b1) begin
         n_fail++; $display("FAIL reset_running: got %b, required 1", swif.running);
      end
      n_checks++;
      if (swif.sec_tick !== 1'b0) begin
         n_fail++; $display("FAIL reset_tick: got %b, required 0", swif.sec_tick);
      end
      rst = 1'b0;
   endtask

   task automatic test_run();
      int ticks = 0;
      for (int i = 1; i <= 8; i++) begin
         tick_edge();
         if (swif.sec_tick === 1'b1) ticks++;
         if (i == 3 || i == 4 || i == 8) begin
            n_checks++;
            if (int'(swif.sec) != ((i == 3) ? 0 : i / 4)) begin
               n_fail++; $display("FAIL run_sec edge %0d: got %0d, required %0d", i, swif.sec, (i == 3) ? 0 : i / 4);
            end
         end
      end
      n_checks++;
      if (ticks != 2 || swif.running !== 1'b1) begin
         n_fail++; $display("FAIL run_ticks: got ticks=%0d running=%b, required 2 and 1", ticks, swif.running);
      end
   endtask

   task automatic test_pause_resume();
      int cnt = 0;
      bit moved = 0;
      while (m_part != 2 && cnt < 10) begin tick_edge(); cnt++; end
      pulse_pause();
      n_checks++;
      if (swif.running !== 1'b0) begin
         n_fail++; $display("FAIL pause_running: got %b, required 0", swif.running);
      end
      for (int i = 0; i < 20; i++) begin
         tick_edge();
         if (swif.sec !== 6'd2 || swif.min !== 6'd0 || swif.sec_tick !== 1'b0) moved = 1;
      end
      n_checks++;
      if (moved) begin
         n_fail++; $display("FAIL pause_hold: time moved while paused, now %0d:%0d, required 0:2", swif.min, swif.sec);
      end
      pulse_pause();
      n_checks++;
      if (swif.running !== 1'b1) begin
         n_fail++; $display("FAIL resume_running: got %b, required 1", swif.running);
      end
      cnt = 0;
      while (swif.sec === 6'd2 && cnt < 10) begin tick_edge(); cnt++; end
      n_checks++;
      if (cnt != 2 || swif.sec !== 6'd3) begin
         n_fail++; $display("FAIL resume_latency: got %0d edges sec=%0d, required 2 edges sec=3", cnt, swif.sec);
      end
   endtask

   task automatic test_rollover();
      set_time(0, 59);
      for (int i = 1; i <= 3; i++) tick_edge();
      n_checks++;
      if (swif.min !== 6'd0 || swif.sec !== 6'd59) begin
         n_fail++; $display("FAIL rollover_early: got %0d:%0d, required 0:59", swif.min, swif.sec);
      end
      tick_edge();
      n_checks++;
      if (swif.min !== 6'd1 || swif.sec !== 6'd0 || swif.sec_tick !== 1'b1) begin
         n_fail++; $display("FAIL rollover: got %0d:%0d tick=%b, required 1:0 tick=1", swif.min, swif.sec, swif.sec_tick);
      end
   endtask

   task automatic test_boundary();
      int ticks = 0;
      set_time(59, 59);
      for (int i = 0; i < 4; i++) begin
         tick_edge();
         if (swif.sec_tick === 1'b1) ticks++;
      end
`ifdef STOPWATCH_SATURATE_EN
      for (int i = 0; i < 8; i++) begin
         tick_edge();
         if (swif.sec_tick === 1'b1) ticks++;
      end
      n_checks++;
      if (swif.min !== 6'd59 || swif.sec !== 6'd59 || swif.running !== 1'b0 || ticks != 0) begin
         n_fail++; $display("FAIL saturate: got %0d:%0d running=%b ticks=%0d, required 59:59 running=0 ticks=0", swif.min, swif.sec, swif.running, ticks);
      end
`else
      n_checks++;
      if (swif.min !== 6'd0 || swif.sec !== 6'd0 || ticks != 1 || swif.running !== 1'b1) begin
         n_fail++; $display("FAIL wrap_5959: got %0d:%0d running=%b ticks=%0d, required 0:0 running=1 ticks=1", swif.min, swif.sec, swif.running, ticks);
      end
`endif
   endtask

   task automatic test_adjust();
      int cnt = 0;
      int prev = 0;
      set_time(58, 30);
      swif.adjust = 1'b1;
      swif.selection = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick_edge();
         if (i == 2 || i == 3 || i == 5 || i == 7) begin
            n_checks++;
            if (int'(swif.min) != ((i == 2) ? 58 : (i == 3) ? 59 : (i == 5) ? 0 : 1) || swif.sec !== 6'd30) begin
               n_fail++; $display("FAIL adjust_min edge %0d: got %0d:%0d", i, swif.min, swif.sec);
            end
         end
      end
      n_checks++;
      if (swif.running !== 1'b0) begin
         n_fail++; $display("FAIL adjust_running: got %b, required 0", swif.running);
      end
      swif.selection = 1'b1;
      while (swif.sec !== 6'd0 && cnt < 200) begin
         prev = int'(swif.sec);
         tick_edge();
         cnt++;
      end
      n_checks++;
      if (swif.sec !== 6'd0 || prev != 59 || swif.min !== 6'd1) begin
         n_fail++; $display("FAIL adjust_sec_wrap: got %0d:%0d prev_sec=%0d, required 1:0 prev_sec=59", swif.min, swif.sec, prev);
      end
      swif.adjust = 1'b0;
      tick_edge();
   endtask

   task automatic test_priority();
      set_time(12, 34);
      rst = 1'b1;
      swif.pause = 1'b1;
      tick_edge();
      rst = 1'b0;
      swif.pause = 1'b0;
      n_checks++;
      if (swif.min !== 6'd0 || swif.sec !== 6'd0 || swif.running !== 1'b1) begin
         n_fail++; $display("FAIL priority: got %0d:%0d running=%b, required 0:0 running=1", swif.min, swif.sec, swif.running);
      end
      for (int i = 0; i < 4; i++) tick_edge();
      n_checks++;
      if (swif.sec !== 6'd1) begin
         n_fail++; $display("FAIL priority_run: got sec=%0d, required 1", swif.sec);
      end
   endtask

   task automatic test_random();
      rst = 1'b1;
      tick_edge();
      rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         swif.pause = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 39) == 0) swif.adjust = ~swif.adjust;
         if ($urandom_range(0, 9) == 0) swif.selection = ~swif.selection;
         rst = ($urandom_range(0, 499) == 0);
         tick_edge();
         n_checks++;
         if ({swif.min, swif.sec, swif.running, swif.sec_tick} !==
             {6'(m_min), 6'(m_sec), m_run && !m_adj, m_tick}) begin
            n_fail++;
            $display("FAIL random cycle %0d: got %0d:%0d run=%b tick=%b, required %0d:%0d run=%b tick=%b",
                     c, swif.min, swif.sec, swif.running, swif.sec_tick,
                     m_min, m_sec, m_run && !m_adj, m_tick);
         end
      end
      rst = 1'b0;
      swif.pause = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      swif.pause = 1'b0; swif.adjust = 1'b0; swif.selection = 1'b0;
      test_reset();
      test_run();
      test_pause_resume();
      test_rollover();
      test_boundary();
      test_adjust();
      test_priority();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
